// File: rtl/obuf_psum_writeback_pkg.sv
// rtl/obuf_psum_writeback_pkg.sv - shared widths, writeback FSM states and saturation helpers
package obuf_psum_writeback_pkg;

   localparam int DEF_DATA_WIDTH = 8;
   localparam int DEF_ACCU_WIDTH = 24;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DRAIN = 2'd2
   } wb_state_t;

   // Clamp a wide signed value into the range of a w-bit two's complement number.
   function automatic logic signed [63:0] sat_clip(input logic signed [63:0] v, input int w);
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      hi = (64'sd1 <<< (w - 1)) - 64'sd1;
      lo = -(64'sd1 <<< (w - 1));
      if (v > hi) return hi;
      if (v < lo) return lo;
      return v;
   endfunction

   function automatic logic sat_hit(input logic signed [63:0] v, input int w);
      return sat_clip(v, w) != v;
   endfunction

endpackage

// File: rtl/obuf_psum_writeback_if.sv
// rtl/obuf_psum_writeback_if.sv - pe_array beat input and output-buffer result stream
interface obuf_psum_writeback_if #(
   parameter int NUM_OUT_CHANNEL = 8,
   parameter int DATA_WIDTH      = 8,
   parameter int ACCU_WIDTH      = 24,
   parameter int PSUM_DEPTH      = 16
);
   localparam int AW = $clog2(PSUM_DEPTH);

   logic                                acc;
   logic [NUM_OUT_CHANNEL*ACCU_WIDTH-1:0] obuf_write_data;
   logic                                pea_hold;
   logic                                out_valid;
   logic                                out_ready;
   logic [NUM_OUT_CHANNEL*DATA_WIDTH-1:0] out_data;
   logic [AW-1:0]                       out_addr;

   modport master (
      output acc, obuf_write_data, out_ready,
      input  pea_hold, out_valid, out_data, out_addr
   );

   modport slave (
      input  acc, obuf_write_data, out_ready,
      output pea_hold, out_valid, out_data, out_addr
   );

endinterface

// File: rtl/obuf_psum_writeback_requant_lane.sv
// rtl/obuf_psum_writeback_requant_lane.sv - one lane: round-half-up shift, optional relu, int8 saturate
module obuf_psum_writeback_requant_lane
   import obuf_psum_writeback_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int ACCU_WIDTH = DEF_ACCU_WIDTH
) (
   input  logic signed [ACCU_WIDTH-1:0] psum,
   input  logic [4:0]                   shift,
   input  logic                         relu,
   output logic signed [DATA_WIDTH-1:0] q,
   output logic                         sat
);

   logic signed [63:0] wide;
   logic signed [63:0] rnd;
   logic signed [63:0] r;

   always_comb begin
      wide = 64'(psum);
      rnd  = 64'sd1 <<< (shift - 5'd1);
      r    = (shift != 5'd0) ? ((wide + rnd) >>> shift) : wide;
      if (relu && (r < 64'sd0)) r = 64'sd0;
      q   = DATA_WIDTH'(sat_clip(r, DATA_WIDTH));
      sat = sat_hit(r, DATA_WIDTH);
   end

endmodule

// File: rtl/obuf_psum_writeback.sv
// rtl/obuf_psum_writeback.sv - multi-pass psum accumulation, int8 requant and result FIFO
module obuf_psum_writeback
   import obuf_psum_writeback_pkg::*;
#(
   parameter int NUM_OUT_CHANNEL = 8,
   parameter int DATA_WIDTH      = DEF_DATA_WIDTH,
   parameter int ACCU_WIDTH      = DEF_ACCU_WIDTH,
   parameter int PSUM_DEPTH      = 16,
   parameter int OFIFO_DEPTH     = 4
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        enable,
   input  logic                        start,
   input  logic [$clog2(PSUM_DEPTH):0] cfg_num_pos,
   input  logic [7:0]                  cfg_num_pass,
   input  logic [4:0]                  cfg_shift,
   input  logic                        cfg_relu,
   obuf_psum_writeback_if.slave        bus,
   output logic                        busy,
   output logic                        done,
   output logic                        sat_flag
);

   localparam int AW = $clog2(PSUM_DEPTH);
   localparam int FW = $clog2(OFIFO_DEPTH);
   localparam int CW = FW + 1;
   localparam int BW = NUM_OUT_CHANNEL * ACCU_WIDTH;
   localparam int OW = NUM_OUT_CHANNEL * DATA_WIDTH;
   localparam logic [CW:0] HOLD_TH = (CW+1)'(OFIFO_DEPTH - 1);

   wb_state_t     state;
   logic [AW:0]   num_pos_q;
   logic [7:0]    num_pass_q;
   logic [4:0]    shift_q;
   logic          relu_q;
   logic [AW-1:0] pos_q;
   logic [7:0]    pass_q;

   logic          s1_valid;
   logic          s1_first;
   logic          s1_last;
   logic [AW-1:0] s1_pos;
   logic [BW-1:0] s1_beat;
   logic [BW-1:0] s1_old;

   logic [BW-1:0]    ram [PSUM_DEPTH];
   logic [OW+AW-1:0] fifo_mem [OFIFO_DEPTH];
   logic [FW-1:0]    wr_ptr;
   logic [FW-1:0]    rd_ptr;
   logic [CW-1:0]    count;
   logic             pea_hold_q;

   logic [BW-1:0]              sum1;
   logic [NUM_OUT_CHANNEL-1:0] lane_sat;
   logic                       add_sat;
   logic [OW-1:0]              q_data;
   logic [NUM_OUT_CHANNEL-1:0] q_sat;

   logic          cap;
   logic          cur_last;
   logic          pos_wrap;
   logic          push;
   logic          push_ok;
   logic          pop;
   logic          full_drop;
   logic          inflight_n;
   logic [CW-1:0] count_n;
   logic [BW-1:0] old_n;

   // Stage 1: pass 0 writes the beat, later passes add the RAM value with per-lane clamp.
   for (genvar k = 0; k < NUM_OUT_CHANNEL; k++) begin : g_lane
      logic signed [63:0]    full;
      logic [ACCU_WIDTH-1:0] clipped;

      assign full = 64'($signed(s1_old[k*ACCU_WIDTH +: ACCU_WIDTH]))
                  + 64'($signed(s1_beat[k*ACCU_WIDTH +: ACCU_WIDTH]));
      assign clipped = ACCU_WIDTH'(sat_clip(full, ACCU_WIDTH));
      assign sum1[k*ACCU_WIDTH +: ACCU_WIDTH] =
         s1_first ? s1_beat[k*ACCU_WIDTH +: ACCU_WIDTH] : clipped;
      assign lane_sat[k] = ~s1_first & sat_hit(full, ACCU_WIDTH);

      obuf_psum_writeback_requant_lane #(
         .DATA_WIDTH(DATA_WIDTH),
         .ACCU_WIDTH(ACCU_WIDTH)
      ) u_requant (
         .psum  (sum1[k*ACCU_WIDTH +: ACCU_WIDTH]),
         .shift (shift_q),
         .relu  (relu_q),
         .q     (q_data[k*DATA_WIDTH +: DATA_WIDTH]),
         .sat   (q_sat[k])
      );
   end

   assign add_sat   = |lane_sat;
   assign pos_wrap  = ({1'b0, pos_q} == num_pos_q - (AW+1)'(1));
   assign cur_last  = (pass_q == num_pass_q - 8'd1);
   assign cap       = enable && (state == ACCUM) && bus.acc;
   assign push      = enable && s1_valid && s1_last;
   assign pop       = enable && bus.out_valid && bus.out_ready;
   assign push_ok   = push && ((count != CW'(OFIFO_DEPTH)) || pop);
   assign full_drop = push && !push_ok;
   assign count_n   = count + CW'(push_ok) - CW'(pop);
   assign inflight_n = enable ? (cap && cur_last) : (s1_valid && s1_last);

   // The RAM write of the beat in stage 1 lands at the same edge this read samples, so forward it.
   assign old_n = (s1_valid && !s1_last && (s1_pos == pos_q)) ? sum1 : ram[pos_q];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         num_pos_q  <= '0;
         num_pass_q <= '0;
         shift_q    <= '0;
         relu_q     <= 1'b0;
         pos_q      <= '0;
         pass_q     <= '0;
         s1_valid   <= 1'b0;
         s1_first   <= 1'b0;
         s1_last    <= 1'b0;
         s1_pos     <= '0;
         s1_beat    <= '0;
         s1_old     <= '0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         pea_hold_q <= 1'b0;
         done       <= 1'b0;
         sat_flag   <= 1'b0;
      end else begin
         done <= 1'b0;
         if (enable) begin
            s1_valid <= cap;
            if (cap) begin
               s1_pos   <= pos_q;
               s1_beat  <= bus.obuf_write_data;
               s1_old   <= old_n;
               s1_first <= (pass_q == 8'd0);
               s1_last  <= cur_last;
               if (pos_wrap) begin
                  pos_q  <= '0;
                  pass_q <= pass_q + 8'd1;
               end else begin
                  pos_q <= pos_q + AW'(1);
               end
            end
            if (push_ok) wr_ptr <= wr_ptr + FW'(1);
            if (pop) rd_ptr <= rd_ptr + FW'(1);
            count <= count_n;
            if ((s1_valid && add_sat) || (push && (|q_sat)) || full_drop) sat_flag <= 1'b1;
            case (state)
               IDLE: if (start) begin
                  num_pos_q  <= cfg_num_pos;
                  num_pass_q <= cfg_num_pass;
                  shift_q    <= cfg_shift;
                  relu_q     <= cfg_relu;
                  pos_q      <= '0;
                  pass_q     <= '0;
                  sat_flag   <= 1'b0;
                  state      <= ACCUM;
               end
               ACCUM: if (cap && pos_wrap && cur_last) state <= DRAIN;
               DRAIN: if ((count_n == '0) && !s1_valid) begin
                  state <= IDLE;
                  done  <= 1'b1;
               end
               default: state <= IDLE;
            endcase
         end
         pea_hold_q <= ({1'b0, count_n} + (CW+1)'(inflight_n)) >= HOLD_TH;
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) fifo_mem[wr_ptr] <= {s1_pos, q_data};
      if (enable && s1_valid && !s1_last) ram[s1_pos] <= sum1;
   end

   assign bus.out_valid = (count != '0);
   assign bus.out_data  = bus.out_valid ? fifo_mem[rd_ptr][OW-1:0] : '0;
   assign bus.out_addr  = bus.out_valid ? fifo_mem[rd_ptr][OW +: AW] : '0;
   assign bus.pea_hold  = pea_hold_q | ~enable;
   assign busy          = (state != IDLE);

endmodule

// File: tb/tb_obuf_psum_writeback.sv
// tb/tb_obuf_psum_writeback.sv - directed self-checking bench for obuf_psum_writeback
module tb_obuf_psum_writeback;

   localparam int NCH = 8;
   localparam int DW  = 8;
   localparam int AWD = 24;
   localparam int PD  = 16;
   localparam int FD  = 4;

   logic       clk = 1'b0;
   logic       reset;
   logic       enable;
   logic       start;
   logic [4:0] cfg_num_pos;
   logic [7:0] cfg_num_pass;
   logic [4:0] cfg_shift;
   logic       cfg_relu;
   logic       busy;
   logic       done;
   logic       sat_flag;

   int compared   = 0;
   int mismatched = 0;
   int ndone;
   int hold_seen;
   int lv [NCH];

   logic [NCH*AWD-1:0] beat_q [$];
   logic [NCH*DW-1:0]  exp_d [$];
   logic [3:0]         exp_a [$];

   obuf_psum_writeback_if #(
      .NUM_OUT_CHANNEL(NCH), .DATA_WIDTH(DW), .ACCU_WIDTH(AWD), .PSUM_DEPTH(PD)
   ) bus ();

   obuf_psum_writeback #(
      .NUM_OUT_CHANNEL(NCH), .DATA_WIDTH(DW), .ACCU_WIDTH(AWD),
      .PSUM_DEPTH(PD), .OFIFO_DEPTH(FD)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .enable       (enable),
      .start        (start),
      .cfg_num_pos  (cfg_num_pos),
      .cfg_num_pass (cfg_num_pass),
      .cfg_shift    (cfg_shift),
      .cfg_relu     (cfg_relu),
      .bus          (bus.slave),
      .busy         (busy),
      .done         (done),
      .sat_flag     (sat_flag)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [NCH*AWD-1:0] rep24(input int v);
      logic [NCH*AWD-1:0] r;
      for (int k = 0; k < NCH; k++) r[k*AWD +: AWD] = v[AWD-1:0];
      return r;
   endfunction

   function automatic logic [NCH*DW-1:0] rep8(input int v);
      logic [NCH*DW-1:0] r;
      for (int k = 0; k < NCH; k++) r[k*DW +: DW] = v[DW-1:0];
      return r;
   endfunction

   function automatic logic [NCH*AWD-1:0] pack24(input int a [NCH]);
      logic [NCH*AWD-1:0] r;
      for (int k = 0; k < NCH; k++) r[k*AWD +: AWD] = a[k][AWD-1:0];
      return r;
   endfunction

   function automatic logic [NCH*DW-1:0] pack8(input int a [NCH]);
      logic [NCH*DW-1:0] r;
      for (int k = 0; k < NCH; k++) r[k*DW +: DW] = a[k][DW-1:0];
      return r;
   endfunction

   task automatic clear_queues();
      beat_q.delete();
      exp_d.delete();
      exp_a.delete();
   endtask

   task automatic start_tile(input int np, input int npass, input int sh, input logic relu);
      @(negedge clk);
      cfg_num_pos  = 5'(np);
      cfg_num_pass = 8'(npass);
      cfg_shift    = 5'(sh);
      cfg_relu     = relu;
      start        = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("busy_after_start", 64'(busy), 64'd1);
   endtask

   // Feeds beat_q while honouring pea_hold, pops with out_ready from cycle ready_at on.
   task automatic run_tile(input int ready_at, output int nd, output int hs);
      int idx = 0;
      int cyc = 0;
      nd = 0;
      hs = 0;
      while (cyc < 3000 && !(idx == exp_d.size() && nd > 0)) begin
         @(negedge clk);
         if (done) nd++;
         if (bus.pea_hold) hs = 1;
         bus.out_ready = (cyc >= ready_at);
         if (bus.out_valid && bus.out_ready) begin
            if (idx < exp_d.size()) begin
               check($sformatf("out_data[%0d]", idx), 64'(bus.out_data), 64'(exp_d[idx]));
               check($sformatf("out_addr[%0d]", idx), 64'(bus.out_addr), 64'(exp_a[idx]));
            end else begin
               check("extra_output", 64'(idx), 64'(exp_d.size()));
            end
            idx++;
         end
         if (beat_q.size() > 0 && !bus.pea_hold) begin
            bus.acc = 1'b1;
            bus.obuf_write_data = beat_q.pop_front();
         end else begin
            bus.acc = 1'b0;
         end
         cyc++;
      end
      bus.acc = 1'b0;
      check("outputs_seen", 64'(idx), 64'(exp_d.size()));
      repeat (3) begin
         @(negedge clk);
         if (done) nd++;
      end
      bus.out_ready = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      enable = 1'b1;
      start = 1'b0;
      cfg_num_pos = '0;
      cfg_num_pass = '0;
      cfg_shift = '0;
      cfg_relu = 1'b0;
      bus.acc = 1'b0;
      bus.obuf_write_data = '0;
      bus.out_ready = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check("rst_pea_hold", 64'(bus.pea_hold), 64'd0);
      check("rst_out_valid", 64'(bus.out_valid), 64'd0);
      check("rst_out_data", 64'(bus.out_data), 64'd0);
      check("rst_out_addr", 64'(bus.out_addr), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      check("rst_sat", 64'(sat_flag), 64'd0);

      // Single pass, shift 0: large beats saturate to int8.
      clear_queues();
      beat_q = '{rep24(10), rep24(-5), rep24(200), rep24(-200)};
      exp_d  = '{rep8(10), rep8(-5), rep8(127), rep8(-128)};
      exp_a  = '{4'd0, 4'd1, 4'd2, 4'd3};
      start_tile(4, 1, 0, 1'b0);
      run_tile(0, ndone, hold_seen);
      check("t1_done_count", 64'(ndone), 64'd1);
      check("t1_sat", 64'(sat_flag), 64'd1);
      check("t1_busy_end", 64'(busy), 64'd0);

      // Rounding with shift=1, mixed lanes.
      clear_queues();
      lv = '{3, -3, 5, -5, 0, 1, -1, 254};
      beat_q.push_back(pack24(lv));
      lv = '{2, -1, 3, -2, 0, 1, 0, 127};
      exp_d.push_back(pack8(lv));
      exp_a.push_back(4'd0);
      start_tile(1, 1, 1, 1'b0);
      run_tile(0, ndone, hold_seen);
      check("rnd_done_count", 64'(ndone), 64'd1);
      check("rnd_sat", 64'(sat_flag), 64'd0);

      // Same beat with relu.
      clear_queues();
      lv = '{3, -3, 5, -5, 0, 1, -1, 254};
      beat_q.push_back(pack24(lv));
      lv = '{2, 0, 3, 0, 0, 1, 0, 127};
      exp_d.push_back(pack8(lv));
      exp_a.push_back(4'd0);
      start_tile(1, 1, 1, 1'b1);
      run_tile(0, ndone, hold_seen);
      check("relu_done_count", 64'(ndone), 64'd1);

      // 16 positions x 3 passes of 100, shift 2: (300+2)>>2 = 75.
      clear_queues();
      for (int p = 0; p < 3; p++)
         for (int i = 0; i < 16; i++) beat_q.push_back(rep24(100));
      for (int i = 0; i < 16; i++) begin
         exp_d.push_back(rep8(75));
         exp_a.push_back(4'(i));
      end
      start_tile(16, 3, 2, 1'b0);
      run_tile(0, ndone, hold_seen);
      check("t2_done_count", 64'(ndone), 64'd1);
      check("t2_sat", 64'(sat_flag), 64'd0);

      // One position, back-to-back passes: 5+7+11 needs the write forwarding.
      clear_queues();
      beat_q = '{rep24(5), rep24(7), rep24(11)};
      exp_d  = '{rep8(23)};
      exp_a  = '{4'd0};
      start_tile(1, 3, 0, 1'b0);
      run_tile(0, ndone, hold_seen);
      check("byp_done_count", 64'(ndone), 64'd1);
      check("byp_sat", 64'(sat_flag), 64'd0);

      // Psum clamps at 0x7FFFFF, then shift 16 rounds to 128 and saturates to 127.
      clear_queues();
      beat_q = '{rep24(32'h7FFFFF), rep24(32'h7FFFFF)};
      exp_d  = '{rep8(127)};
      exp_a  = '{4'd0};
      start_tile(1, 2, 16, 1'b0);
      run_tile(0, ndone, hold_seen);
      check("accsat_sat", 64'(sat_flag), 64'd1);

      // Stalled downstream: pea_hold must throttle without losing beats.
      clear_queues();
      for (int i = 0; i < 16; i++) begin
         beat_q.push_back(rep24(i * 3 - 20));
         exp_d.push_back(rep8(i * 3 - 20));
         exp_a.push_back(4'(i));
      end
      start_tile(16, 1, 0, 1'b0);
      run_tile(14, ndone, hold_seen);
      check("hold_seen", 64'(hold_seen), 64'd1);
      check("hold_done_count", 64'(ndone), 64'd1);
      check("hold_no_drop_sat", 64'(sat_flag), 64'd0);

      // Reset while a result is pending in pass 1.
      start_tile(2, 2, 0, 1'b0);
      for (int i = 1; i <= 3; i++) begin
         @(negedge clk);
         bus.acc = 1'b1;
         bus.obuf_write_data = rep24(i);
      end
      @(negedge clk);
      bus.acc = 1'b0;
      @(negedge clk);
      check("pre_reset_out_valid", 64'(bus.out_valid), 64'd1);
      reset = 1'b1;
      #1;
      check("mid_reset_busy", 64'(busy), 64'd0);
      check("mid_reset_out_valid", 64'(bus.out_valid), 64'd0);
      check("mid_reset_out_data", 64'(bus.out_data), 64'd0);
      @(negedge clk);
      check("mid_reset_done", 64'(done), 64'd0);
      reset = 1'b0;

      clear_queues();
      beat_q = '{rep24(1), rep24(2), rep24(3), rep24(4)};
      exp_d  = '{rep8(4), rep8(6)};
      exp_a  = '{4'd0, 4'd1};
      start_tile(2, 2, 0, 1'b0);
      run_tile(0, ndone, hold_seen);
      check("post_reset_done_count", 64'(ndone), 64'd1);
      check("post_reset_sat", 64'(sat_flag), 64'd0);

      enable = 1'b0;
      #1;
      check("disable_pea_hold", 64'(bus.pea_hold), 64'd1);
      enable = 1'b1;
      @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
